// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states,
// ALU-compatible flag positions and the special-case (zero / overflow) evaluator.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] res;
    logic [3:0]  flg;
  } special_t;

  function automatic logic [3:0] mk_flags(input logic [31:0] res, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = res[31];
    f[FLAG_Z] = (res == 32'd0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  // Cases whose answer is fixed by the ISA rather than by the iterative core
  function automatic special_t special_case(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    special_t s;
    logic     dz, ovf, mz;
    dz    = op[2] && (b == 32'd0);
    ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    mz    = !op[2] && ((a == 32'd0) || (b == 32'd0));
    s.hit = dz || ovf || mz;
    s.res = 32'd0;
    s.flg = mk_flags(32'd0, 1'b0, 1'b0);
    if (dz) begin
      s.res = op[1] ? a : 32'hFFFF_FFFF;
      s.flg = mk_flags(s.res, 1'b1, 1'b0);
    end else if (ovf) begin
      s.res = op[1] ? 32'd0 : 32'h8000_0000;
      s.flg = mk_flags(s.res, 1'b0, 1'b1);
    end
    return s;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/ready request bus between the EX stage (master) and the multiply/divide unit (slave).
interface muldiv_if;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (output start, kill, op, a, b, input ready, busy, done, result, flags);
  modport slave  (input start, kill, op, a, b, output ready, busy, done, result, flags);
endinterface

// File: rtl/muldiv_sign_ctl.sv
// Sign handling around the unsigned core: operand magnitudes at accept time and
// final negation of product, quotient and remainder.
module muldiv_sign_ctl
  import muldiv_pkg::*;
(
  input  logic [2:0]  op_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        sa,
  output logic        sb,
  input  logic [2:0]  op_r,
  input  logic        sa_r,
  input  logic        sb_r,
  input  logic [63:0] acc,
  output logic [31:0] core_res
);

  logic        a_signed, b_signed;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    a_signed = !((op_in == OP_MULHU) || (op_in == OP_DIVU) || (op_in == OP_REMU));
    b_signed = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    sa       = a_signed && a_in[31];
    sb       = b_signed && b_in[31];
    mag_a    = sa ? (32'd0 - a_in) : a_in;
    mag_b    = sb ? (32'd0 - b_in) : b_in;
  end

  // acc holds {hi, lo} of the product, or {remainder, quotient} for divides
  always_comb begin
    prod_fix = (sa_r ^ sb_r) ? (64'd0 - acc) : acc;
    quo_fix  = (sa_r ^ sb_r) ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix  = sa_r ? (32'd0 - acc[63:32]) : acc[63:32];
    if (op_r[2]) core_res = op_r[1] ? rem_fix : quo_fix;
    else         core_res = (op_r == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add / restoring-divide steps, done pulse after.
// Build option MULDIV_EARLY_OUT_EN: zero-operand multiplies, divide by zero and overflow finish in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  muldiv_if.slave bus
);

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [2:0]  op_r;
  logic [31:0] a_r, b_r, mag_a_r, mag_b_r;
  logic        sa_r, sb_r;
  logic [63:0] acc, acc_n;
  logic [31:0] mag_a, mag_b, core_res;
  logic        sa, sb;
  logic [31:0] result_q;
  logic [3:0]  flags_q;
  logic        accept, finish, early;
  logic [31:0] early_res;
  logic [3:0]  early_flg;
  logic [32:0] sum, shifted, diff;
  special_t    sp_r;

`ifdef MULDIV_EARLY_OUT_EN
  special_t sp_in;
  assign sp_in     = special_case(bus.op, bus.a, bus.b);
  assign early     = sp_in.hit;
  assign early_res = sp_in.res;
  assign early_flg = sp_in.flg;
`else
  assign early     = 1'b0;
  assign early_res = 32'd0;
  assign early_flg = 4'd0;
`endif

  assign sp_r = special_case(op_r, a_r, b_r);

  muldiv_sign_ctl u_sign (
    .op_in(bus.op), .a_in(bus.a), .b_in(bus.b),
    .mag_a(mag_a), .mag_b(mag_b), .sa(sa), .sb(sb),
    .op_r(op_r), .sa_r(sa_r), .sb_r(sb_r), .acc(acc_n), .core_res(core_res)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        accept  = bus.start && !bus.kill;
        state_n = accept ? (early ? DONE : CALC) : IDLE;
      end
      CALC: if (cnt == 5'd31) begin
        finish  = !bus.kill;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (bus.kill) state_n = IDLE;
  end

  // One core step: multiply adds then shifts right, divide shifts left then trial-subtracts
  always_comb begin
    sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a_r} : 33'd0);
    shifted = {acc[63:32], acc[31]};
    diff    = shifted - {1'b0, mag_b_r};
    if (op_r[2]) acc_n = diff[32] ? {shifted[31:0], acc[30:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    else         acc_n = {sum, acc[31:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      result_q <= 32'd0;
      flags_q  <= 4'd0;
    end else begin
      state <= state_n;
      if (accept)              cnt <= 5'd0;
      else if (state == CALC)  cnt <= cnt + 5'd1;
      if (accept && early) begin
        result_q <= early_res;
        flags_q  <= early_flg;
      end else if (finish) begin
        result_q <= sp_r.hit ? sp_r.res : core_res;
        flags_q  <= sp_r.hit ? sp_r.flg : mk_flags(core_res, 1'b0, 1'b0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r    <= bus.op;
      a_r     <= bus.a;
      b_r     <= bus.b;
      sa_r    <= sa;
      sb_r    <= sb;
      mag_a_r <= mag_a;
      mag_b_r <= mag_b;
      acc     <= {32'd0, bus.op[2] ? mag_a : mag_b};
    end else if (state == CALC) begin
      acc <= acc_n;
    end
  end

  assign bus.ready  = (state != CALC);
  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table run back-to-back, then kill, start-while-busy
// and mid-operation reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;

  muldiv_if bus ();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    bit          early;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 (first cycle after accept)
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat, output int nbusy);
    lat   = from;
    nbusy = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat, nb, nd;
    logic [31:0] last;

    vecs[0]  = '{"mul_5x5",      OP_MUL,    32'd5,          32'd5,          32'd25,         4'b0000, 1'b0};
    vecs[1]  = '{"mulh_m1m1",    OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  4'b0100, 1'b0};
    vecs[2]  = '{"mulhu_max",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  4'b1000, 1'b0};
    vecs[3]  = '{"div_7_m2",     OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  4'b1000, 1'b0};
    vecs[4]  = '{"rem_7_m2",     OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          4'b0000, 1'b0};
    vecs[5]  = '{"divu_by0",     OP_DIVU,   32'd9,          32'd0,          32'hFFFF_FFFF,  4'b1010, 1'b1};
    vecs[6]  = '{"div_ovf",      OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  4'b1001, 1'b1};
    vecs[7]  = '{"rem_ovf",      OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          4'b0101, 1'b1};
    vecs[8]  = '{"mulhsu_m1_2",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  4'b1000, 1'b0};
    vecs[9]  = '{"remu_by0",     OP_REMU,   32'd9,          32'd0,          32'd9,          4'b0010, 1'b1};
    vecs[10] = '{"mul_zero",     OP_MUL,    32'd0,          32'd12345,      32'd0,          4'b0100, 1'b1};
    vecs[11] = '{"divu_100_7",   OP_DIVU,   32'd100,        32'd7,          32'd14,         4'b0000, 1'b0};
    vecs[12] = '{"mul_m3_7",     OP_MUL,    32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB,  4'b1000, 1'b0};
    vecs[13] = '{"div_m7_2",     OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  4'b1000, 1'b0};
    vecs[14] = '{"rem_m7_2",     OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  4'b1000, 1'b0};
    vecs[15] = '{"mulh_2p32",    OP_MULH,   32'h4000_0000,  32'd4,          32'd1,          4'b0000, 1'b0};

    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(bus.ready), 32'd1);
    check("rst_busy",   32'(bus.busy),  32'd0);
    check("rst_done",   32'(bus.done),  32'd0);
    check("rst_result", bus.result,     32'd0);
    check("rst_flags",  32'(bus.flags), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Each vector after the first is issued in the previous op's done cycle
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, lat, nb);
      check({vecs[i].name, "_lat"},   32'(lat), (EARLY && vecs[i].early) ? 32'd1 : 32'd33);
      check({vecs[i].name, "_busy"},  32'(nb),  (EARLY && vecs[i].early) ? 32'd0 : 32'd32);
      check({vecs[i].name, "_res"},   bus.result, vecs[i].res);
      check({vecs[i].name, "_flags"}, 32'(bus.flags), 32'(vecs[i].flg));
      check({vecs[i].name, "_ready"}, 32'(bus.ready), 32'd1);
    end
    last = vecs[NV-1].res;

    // kill at cycle 10 of a multiply
    @(negedge clk);
    issue(OP_MUL, 32'd3, 32'd3);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy",  32'(bus.busy),  32'd0);
    check("kill_ready", 32'(bus.ready), 32'd1);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    check("kill_no_done", 32'(nd), 32'd0);
    check("kill_result",  bus.result, last);

    // start at cycle 5 of a busy op is ignored
    issue(OP_MUL, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, lat, nb);
    check("busy_start_lat", 32'(lat), 32'd33);
    check("busy_start_res", bus.result, 32'd42);
    check("busy_start_flags", 32'(bus.flags), 32'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    check("busy_start_no_queue", 32'(nd), 32'd0);

    // asynchronous reset at cycle 20
    issue(OP_MUL, 32'd5, 32'd5);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ready",  32'(bus.ready), 32'd1);
    check("midrst_busy",   32'(bus.busy),  32'd0);
    check("midrst_done",   32'(bus.done),  32'd0);
    check("midrst_result", bus.result,     32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(OP_MUL, 32'd5, 32'd5);
    wait_done(1, lat, nb);
    check("postrst_lat", 32'(lat), 32'd33);
    check("postrst_res", bus.result, 32'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
